// File: rtl/tvip_axi_types_pkg.sv
// Shared AXI types for the tvip-axi models: burst encodings, beat index type,
// pack/unpack helpers and burst legality / wrap-boundary helpers.
package tvip_axi_types_pkg;

  localparam int unsigned TVIP_AXI_MAX_ADDRESS_WIDTH = 64;

  typedef enum logic [1:0] {
    TVIP_AXI_FIXED_BURST        = 2'b00,
    TVIP_AXI_INCREMENTING_BURST = 2'b01,
    TVIP_AXI_WRAPPING_BURST     = 2'b10
  } tvip_axi_burst_type;

  typedef enum logic [2:0] {
    TVIP_AXI_BURST_SIZE_1_BYTE    = 3'd0,
    TVIP_AXI_BURST_SIZE_2_BYTES   = 3'd1,
    TVIP_AXI_BURST_SIZE_4_BYTES   = 3'd2,
    TVIP_AXI_BURST_SIZE_8_BYTES   = 3'd3,
    TVIP_AXI_BURST_SIZE_16_BYTES  = 3'd4,
    TVIP_AXI_BURST_SIZE_32_BYTES  = 3'd5,
    TVIP_AXI_BURST_SIZE_64_BYTES  = 3'd6,
    TVIP_AXI_BURST_SIZE_128_BYTES = 3'd7
  } tvip_axi_burst_size;

  typedef bit [7:0] tvip_axi_beat_index;

  // Beat count -> AxLEN encoding.
  function automatic logic [7:0] pack_burst_length(input int unsigned burst_length);
    return 8'(burst_length - 32'd1);
  endfunction

  // AxLEN encoding -> beat count.
  function automatic int unsigned unpack_burst_length(input logic [7:0] burst_length);
    return 32'(burst_length) + 32'd1;
  endfunction

  // Bytes per beat -> AxSIZE encoding.
  function automatic logic [2:0] pack_burst_size(input int unsigned burst_size);
    return 3'($clog2(burst_size));
  endfunction

  // AxSIZE encoding -> bytes per beat.
  function automatic int unsigned unpack_burst_size(input logic [2:0] burst_size);
    return 32'd1 << burst_size;
  endfunction

  // Lowest address of the S*L byte window a WRAP burst cycles through.
  function automatic logic [TVIP_AXI_MAX_ADDRESS_WIDTH-1:0] calc_wrap_boundary(
    input logic [TVIP_AXI_MAX_ADDRESS_WIDTH-1:0] address,
    input logic [2:0]                            burst_size,
    input logic [7:0]                            burst_length
  );
    logic [TVIP_AXI_MAX_ADDRESS_WIDTH-1:0] span;
    span = TVIP_AXI_MAX_ADDRESS_WIDTH'(unpack_burst_size(burst_size) *
                                        unpack_burst_length(burst_length));
    return address & ~(span - TVIP_AXI_MAX_ADDRESS_WIDTH'(1));
  endfunction

  // Returns 1 when the request obeys the AXI burst rules for an nb_bytes-wide bus.
  function automatic logic is_valid_burst(
    input logic [TVIP_AXI_MAX_ADDRESS_WIDTH-1:0] address,
    input logic [2:0]                            burst_size,
    input logic [7:0]                            burst_length,
    input logic [1:0]                            burst_type,
    input int unsigned                           nb_bytes
  );
    int unsigned size_bytes;
    int unsigned beats;
    int unsigned aligned_low;
    logic        valid;
    size_bytes  = unpack_burst_size(burst_size);
    beats       = unpack_burst_length(burst_length);
    aligned_low = 32'(address[11:0]) & ~(size_bytes - 32'd1);
    valid       = 1'b1;
    if (size_bytes > nb_bytes) valid = 1'b0;
    case (burst_type)
      TVIP_AXI_FIXED_BURST: begin
        if (beats > 32'd16) valid = 1'b0;
      end
      TVIP_AXI_INCREMENTING_BURST: begin
        // An INCR burst may not cross a 4 KB page.
        if ((aligned_low + (beats * size_bytes)) > 32'd4096) valid = 1'b0;
      end
      TVIP_AXI_WRAPPING_BURST: begin
        if (!((beats == 32'd2) || (beats == 32'd4) || (beats == 32'd8) || (beats == 32'd16)))
          valid = 1'b0;
        if ((address & TVIP_AXI_MAX_ADDRESS_WIDTH'(size_bytes - 32'd1)) != '0)
          valid = 1'b0;
      end
      default: valid = 1'b0;
    endcase
    return valid;
  endfunction

endpackage

// File: rtl/tvip_axi_strobe_decoder.sv
// Byte-lane mask for one beat: lanes from address mod NB up to the end of the
// size-aligned container are active.
// Ports: address (beat address), burst_size (AxSIZE), strobe_c (NB-bit lane mask, combinational).
module tvip_axi_strobe_decoder
  import tvip_axi_types_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 64,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic [ADDRESS_WIDTH-1:0]  address,
  input  logic [2:0]                burst_size,
  output logic [DATA_WIDTH/8-1:0]   strobe_c
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned AW = ADDRESS_WIDTH;

  logic [AW-1:0] size_bytes;
  logic [AW-1:0] lo_lane;
  logic [AW-1:0] hi_lane;

  // Contiguous lane range [lo_lane, hi_lane]; never wraps for legal sizes (S <= NB).
  always_comb begin
    size_bytes = AW'(unpack_burst_size(burst_size));
    lo_lane    = address & AW'(NB - 1);
    hi_lane    = ((address & ~(size_bytes - AW'(1))) + size_bytes - AW'(1)) & AW'(NB - 1);
    strobe_c   = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      strobe_c[i] = (AW'(i) >= lo_lane) && (AW'(i) <= hi_lane);
    end
  end

endmodule

// File: rtl/tvip_axi_burst_address_generator.sv
// Expands one AXI address-channel request into per-beat descriptors
// (address, strobe, index, last) for FIXED, INCR and WRAP bursts.
// Illegal requests produce a single flagged beat.
// Ports: aclk/areset (sync active-high); request channel i_request_valid,
// o_request_ready, i_id, i_address, i_burst_length, i_burst_size, i_burst_type;
// beat channel o_beat_valid, i_beat_ready, o_beat_id, o_beat_address,
// o_beat_strobe, o_beat_index, o_beat_last, o_error.
module tvip_axi_burst_address_generator
  import tvip_axi_types_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 64,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ID_WIDTH      = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      i_request_valid,
  output logic                      o_request_ready,
  input  logic [ID_WIDTH-1:0]       i_id,
  input  logic [ADDRESS_WIDTH-1:0]  i_address,
  input  logic [7:0]                i_burst_length,
  input  logic [2:0]                i_burst_size,
  input  logic [1:0]                i_burst_type,
  output logic                      o_beat_valid,
  input  logic                      i_beat_ready,
  output logic [ID_WIDTH-1:0]       o_beat_id,
  output logic [ADDRESS_WIDTH-1:0]  o_beat_address,
  output logic [DATA_WIDTH/8-1:0]   o_beat_strobe,
  output logic [7:0]                o_beat_index,
  output logic                      o_beat_last,
  output logic                      o_error
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned AW  = ADDRESS_WIDTH;
  localparam int unsigned MAW = TVIP_AXI_MAX_ADDRESS_WIDTH;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_n;

  // Burst context captured at acceptance
  logic [AW-1:0] ctx_address_q,   ctx_address_n;
  logic [AW-1:0] ctx_boundary_q,  ctx_boundary_n;
  logic [AW-1:0] ctx_wrap_mask_q, ctx_wrap_mask_n;
  logic [2:0]    ctx_size_q,      ctx_size_n;
  logic [1:0]    ctx_type_q,      ctx_type_n;
  logic [7:0]    ctx_length_q,    ctx_length_n;

  logic                beat_valid_n;
  logic [ID_WIDTH-1:0] beat_id_n;
  logic [AW-1:0]       beat_address_n;
  logic [NB-1:0]       beat_strobe_n;
  logic [7:0]          beat_index_n;
  logic                beat_last_n;
  logic                error_n;

  logic                accept_c;
  logic                beat_done_c;
  logic                req_error_c;
  logic [AW-1:0]       req_boundary_c;
  logic [AW-1:0]       req_wrap_mask_c;
  logic [NB-1:0]       req_strobe_c;
  logic [AW-1:0]       cur_size_bytes_c;
  logic [AW-1:0]       next_address_c;
  logic [NB-1:0]       next_strobe_c;
  tvip_axi_beat_index  next_index_c;

  // Ready may rise in the last-beat handshake cycle so bursts chain without a bubble.
  assign o_request_ready = ~areset &
                           ((state_q == IDLE) | (o_beat_valid & o_beat_last & i_beat_ready));
  assign accept_c        = i_request_valid & o_request_ready;
  assign beat_done_c     = o_beat_valid & i_beat_ready;

  // Request-side decode
  assign req_error_c     = ~is_valid_burst(MAW'(i_address), i_burst_size, i_burst_length,
                                           i_burst_type, NB);
  assign req_boundary_c  = AW'(calc_wrap_boundary(MAW'(i_address), i_burst_size, i_burst_length));
  assign req_wrap_mask_c = AW'(unpack_burst_size(i_burst_size) *
                               unpack_burst_length(i_burst_length)) - AW'(1);

  tvip_axi_strobe_decoder #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_req_strobe (
    .address    (i_address),
    .burst_size (i_burst_size),
    .strobe_c   (req_strobe_c)
  );

  // Address of the following beat, derived from the current one
  always_comb begin
    cur_size_bytes_c = AW'(unpack_burst_size(ctx_size_q));
    next_index_c     = tvip_axi_beat_index'(o_beat_index + 8'd1);
    case (ctx_type_q)
      TVIP_AXI_FIXED_BURST:
        next_address_c = ctx_address_q;
      TVIP_AXI_WRAPPING_BURST:
        next_address_c = ctx_boundary_q |
                         ((o_beat_address + cur_size_bytes_c) & ctx_wrap_mask_q);
      default:
        next_address_c = (o_beat_address & ~(cur_size_bytes_c - AW'(1))) + cur_size_bytes_c;
    endcase
  end

  tvip_axi_strobe_decoder #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_next_strobe (
    .address    (next_address_c),
    .burst_size (ctx_size_q),
    .strobe_c   (next_strobe_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_n         = state_q;
    beat_valid_n    = o_beat_valid;
    beat_id_n       = o_beat_id;
    beat_address_n  = o_beat_address;
    beat_strobe_n   = o_beat_strobe;
    beat_index_n    = o_beat_index;
    beat_last_n     = o_beat_last;
    error_n         = o_error;
    ctx_address_n   = ctx_address_q;
    ctx_boundary_n  = ctx_boundary_q;
    ctx_wrap_mask_n = ctx_wrap_mask_q;
    ctx_size_n      = ctx_size_q;
    ctx_type_n      = ctx_type_q;
    ctx_length_n    = ctx_length_q;

    if (beat_done_c) begin
      if (o_beat_last) begin
        state_n      = IDLE;
        beat_valid_n = 1'b0;
      end else begin
        beat_address_n = next_address_c;
        beat_strobe_n  = next_strobe_c;
        beat_index_n   = next_index_c;
        beat_last_n    = (next_index_c == ctx_length_q);
      end
    end

    // A new request overrides the retiring last beat
    if (accept_c) begin
      state_n         = BUSY;
      beat_valid_n    = 1'b1;
      beat_id_n       = i_id;
      beat_address_n  = i_address;
      beat_strobe_n   = req_error_c ? '0 : req_strobe_c;
      beat_index_n    = 8'd0;
      beat_last_n     = req_error_c | (i_burst_length == 8'd0);
      error_n         = req_error_c;
      ctx_address_n   = i_address;
      ctx_boundary_n  = req_boundary_c;
      ctx_wrap_mask_n = req_wrap_mask_c;
      ctx_size_n      = i_burst_size;
      ctx_type_n      = i_burst_type;
      ctx_length_n    = i_burst_length;
    end
  end

  // State, output and context registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q         <= IDLE;
      o_beat_valid    <= 1'b0;
      o_beat_id       <= '0;
      o_beat_address  <= '0;
      o_beat_strobe   <= '0;
      o_beat_index    <= '0;
      o_beat_last     <= 1'b0;
      o_error         <= 1'b0;
      ctx_address_q   <= '0;
      ctx_boundary_q  <= '0;
      ctx_wrap_mask_q <= '0;
      ctx_size_q      <= '0;
      ctx_type_q      <= '0;
      ctx_length_q    <= '0;
    end else begin
      state_q         <= state_n;
      o_beat_valid    <= beat_valid_n;
      o_beat_id       <= beat_id_n;
      o_beat_address  <= beat_address_n;
      o_beat_strobe   <= beat_strobe_n;
      o_beat_index    <= beat_index_n;
      o_beat_last     <= beat_last_n;
      o_error         <= error_n;
      ctx_address_q   <= ctx_address_n;
      ctx_boundary_q  <= ctx_boundary_n;
      ctx_wrap_mask_q <= ctx_wrap_mask_n;
      ctx_size_q      <= ctx_size_n;
      ctx_type_q      <= ctx_type_n;
      ctx_length_q    <= ctx_length_n;
    end
  end

endmodule

// File: tb/tb_tvip_axi_burst_address_generator.sv
// Directed bench for tvip_axi_burst_address_generator (64-bit address, 32-bit data).
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_tvip_axi_burst_address_generator;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned NB = DW / 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic          i_request_valid;
  logic          o_request_ready;
  logic [IW-1:0] i_id;
  logic [AW-1:0] i_address;
  logic [7:0]    i_burst_length;
  logic [2:0]    i_burst_size;
  logic [1:0]    i_burst_type;
  logic          o_beat_valid;
  logic          i_beat_ready;
  logic [IW-1:0] o_beat_id;
  logic [AW-1:0] o_beat_address;
  logic [NB-1:0] o_beat_strobe;
  logic [7:0]    o_beat_index;
  logic          o_beat_last;
  logic          o_error;

  int compared   = 0;
  int mismatched = 0;

  always #5 aclk = ~aclk;

  tvip_axi_burst_address_generator #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .ID_WIDTH      (IW)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .i_request_valid (i_request_valid),
    .o_request_ready (o_request_ready),
    .i_id            (i_id),
    .i_address       (i_address),
    .i_burst_length  (i_burst_length),
    .i_burst_size    (i_burst_size),
    .i_burst_type    (i_burst_type),
    .o_beat_valid    (o_beat_valid),
    .i_beat_ready    (i_beat_ready),
    .o_beat_id       (o_beat_id),
    .o_beat_address  (o_beat_address),
    .o_beat_strobe   (o_beat_strobe),
    .o_beat_index    (o_beat_index),
    .o_beat_last     (o_beat_last),
    .o_error         (o_error)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expect_beat(input string tag, input logic [63:0] addr, input logic [3:0] strb,
                             input logic [7:0] idx, input logic last, input logic err,
                             input logic [3:0] id);
    check({tag, ".valid"},  64'(o_beat_valid),   64'd1);
    check({tag, ".addr"},   64'(o_beat_address), addr);
    check({tag, ".strobe"}, 64'(o_beat_strobe),  64'(strb));
    check({tag, ".index"},  64'(o_beat_index),   64'(idx));
    check({tag, ".last"},   64'(o_beat_last),    64'(last));
    check({tag, ".error"},  64'(o_error),        64'(err));
    check({tag, ".id"},     64'(o_beat_id),      64'(id));
  endtask

  task automatic request(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] btype);
    i_request_valid = 1'b1;
    i_id            = id;
    i_address       = addr;
    i_burst_length  = len;
    i_burst_size    = size;
    i_burst_type    = btype;
  endtask

  // Error stimulus: id, address, len, size, type
  logic [3:0]  err_id   [3] = '{4'd2, 4'd4, 4'd6};
  logic [63:0] err_addr [3] = '{64'hFFC, 64'h40, 64'h55};
  logic [7:0]  err_len  [3] = '{8'd1, 8'd0, 8'd0};
  logic [2:0]  err_size [3] = '{3'd2, 3'd3, 3'd0};
  logic [1:0]  err_type [3] = '{2'b01, 2'b01, 2'b11};

  initial begin
    areset          = 1'b1;
    i_request_valid = 1'b0;
    i_id            = '0;
    i_address       = '0;
    i_burst_length  = '0;
    i_burst_size    = '0;
    i_burst_type    = '0;
    i_beat_ready    = 1'b0;

    // Reset values
    repeat (2) @(negedge aclk);
    #1;
    check("rst.valid",  64'(o_beat_valid),    64'd0);
    check("rst.addr",   64'(o_beat_address),  64'd0);
    check("rst.strobe", 64'(o_beat_strobe),   64'd0);
    check("rst.index",  64'(o_beat_index),    64'd0);
    check("rst.last",   64'(o_beat_last),     64'd0);
    check("rst.error",  64'(o_error),         64'd0);
    check("rst.id",     64'(o_beat_id),       64'd0);
    check("rst.ready",  64'(o_request_ready), 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("rel.ready", 64'(o_request_ready), 64'd1);

    // INCR unaligned start
    @(negedge aclk);
    i_beat_ready = 1'b1;
    request(4'd3, 64'h1002, 8'd3, 3'd2, 2'b01);
    #1 check("incr.req_ready", 64'(o_request_ready), 64'd1);
    @(negedge aclk); i_request_valid = 1'b0;
    #1 expect_beat("incr0", 64'h1002, 4'b1100, 8'd0, 1'b0, 1'b0, 4'd3);
    @(negedge aclk); #1 expect_beat("incr1", 64'h1004, 4'b1111, 8'd1, 1'b0, 1'b0, 4'd3);
    @(negedge aclk); #1 expect_beat("incr2", 64'h1008, 4'b1111, 8'd2, 1'b0, 1'b0, 4'd3);
    @(negedge aclk); #1 expect_beat("incr3", 64'h100C, 4'b1111, 8'd3, 1'b1, 1'b0, 4'd3);
    check("incr3.ready", 64'(o_request_ready), 64'd1);
    @(negedge aclk); #1 check("incr.done", 64'(o_beat_valid), 64'd0);

    // FIXED byte burst
    @(negedge aclk); request(4'd1, 64'h201, 8'd2, 3'd0, 2'b00);
    @(negedge aclk); i_request_valid = 1'b0;
    #1 expect_beat("fixed0", 64'h201, 4'b0010, 8'd0, 1'b0, 1'b0, 4'd1);
    @(negedge aclk); #1 expect_beat("fixed1", 64'h201, 4'b0010, 8'd1, 1'b0, 1'b0, 4'd1);
    @(negedge aclk); #1 expect_beat("fixed2", 64'h201, 4'b0010, 8'd2, 1'b1, 1'b0, 4'd1);
    @(negedge aclk); #1 check("fixed.done", 64'(o_beat_valid), 64'd0);

    // Back-pressure on beat 1, then a WRAP request chained onto the last beat
    @(negedge aclk); request(4'd5, 64'h100, 8'd3, 3'd2, 2'b01);
    @(negedge aclk); i_request_valid = 1'b0;
    #1 expect_beat("stall0", 64'h100, 4'b1111, 8'd0, 1'b0, 1'b0, 4'd5);
    @(negedge aclk); i_beat_ready = 1'b0;
    #1 expect_beat("stall1", 64'h104, 4'b1111, 8'd1, 1'b0, 1'b0, 4'd5);
    check("stall1.req_ready", 64'(o_request_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      if (k == 4) i_beat_ready = 1'b1;
      #1 expect_beat($sformatf("hold%0d", k), 64'h104, 4'b1111, 8'd1, 1'b0, 1'b0, 4'd5);
    end
    @(negedge aclk); #1 expect_beat("stall2", 64'h108, 4'b1111, 8'd2, 1'b0, 1'b0, 4'd5);
    @(negedge aclk); request(4'd9, 64'h34, 8'd3, 3'd2, 2'b10);
    #1 expect_beat("stall3", 64'h10C, 4'b1111, 8'd3, 1'b1, 1'b0, 4'd5);
    check("b2b.req_ready", 64'(o_request_ready), 64'd1);
    @(negedge aclk); i_request_valid = 1'b0;
    #1 expect_beat("wrap0", 64'h34, 4'b1111, 8'd0, 1'b0, 1'b0, 4'd9);
    @(negedge aclk); #1 expect_beat("wrap1", 64'h38, 4'b1111, 8'd1, 1'b0, 1'b0, 4'd9);
    @(negedge aclk); #1 expect_beat("wrap2", 64'h3C, 4'b1111, 8'd2, 1'b0, 1'b0, 4'd9);
    @(negedge aclk); #1 expect_beat("wrap3", 64'h30, 4'b1111, 8'd3, 1'b1, 1'b0, 4'd9);
    @(negedge aclk); #1 check("wrap.done", 64'(o_beat_valid), 64'd0);

    // Protocol violations: 4 KB crossing, oversize beat, reserved burst type
    for (int e = 0; e < 3; e++) begin
      @(negedge aclk); request(err_id[e], err_addr[e], err_len[e], err_size[e], err_type[e]);
      @(negedge aclk); i_request_valid = 1'b0;
      #1 expect_beat($sformatf("err%0d", e), err_addr[e], 4'b0000, 8'd0, 1'b1, 1'b1, err_id[e]);
      @(negedge aclk); #1 check($sformatf("err%0d.done", e), 64'(o_beat_valid), 64'd0);
    end

    // Reset during beat 2 of a 4-beat INCR
    @(negedge aclk); request(4'd7, 64'h2000, 8'd3, 3'd2, 2'b01);
    @(negedge aclk); i_request_valid = 1'b0;
    #1 expect_beat("ab0", 64'h2000, 4'b1111, 8'd0, 1'b0, 1'b0, 4'd7);
    @(negedge aclk); #1 expect_beat("ab1", 64'h2004, 4'b1111, 8'd1, 1'b0, 1'b0, 4'd7);
    @(negedge aclk); #1 expect_beat("ab2", 64'h2008, 4'b1111, 8'd2, 1'b0, 1'b0, 4'd7);
    areset = 1'b1;
    @(negedge aclk); #1;
    check("abrst.valid", 64'(o_beat_valid),    64'd0);
    check("abrst.ready", 64'(o_request_ready), 64'd0);
    areset = 1'b0;
    #1;
    check("abrel.ready", 64'(o_request_ready), 64'd1);
    check("abrel.valid", 64'(o_beat_valid),    64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk); #1;
      check($sformatf("nostale%0d", k), 64'(o_beat_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
